// File: rtl/vga_frame_checker.sv
// vga_frame_checker: samples the VGA RGB/BLANK/VS stream on pixel-enable
// cycles, checks line/frame geometry against parameters and produces a
// 32-bit signature over all active pixels of each frame. Stops in DONE after
// NUM_FRAMES closed frames until re-armed.
// Optional feature: define VGA_FRAME_CHECKER_CRC_EN to replace the additive
// signature with a CRC-32 (poly 0x04C11DB7, init 0xFFFFFFFF, MSB first).
module vga_frame_checker #(
    parameter int unsigned COLOR_W    = 8,
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned NUM_FRAMES = 1,
    parameter int unsigned CNT_W      = 12
) (
    input  logic               clk_clk,
    input  logic               reset_reset,
    input  logic               arm,
    input  logic               pix_en,
    input  logic               vga_vs,
    input  logic               vga_blank,
    input  logic [COLOR_W-1:0] vga_r,
    input  logic [COLOR_W-1:0] vga_g,
    input  logic [COLOR_W-1:0] vga_b,
    output logic               busy,
    output logic               done,
    output logic               frame_done,
    output logic [31:0]        frame_sig,
    output logic [15:0]        frame_count,
    output logic [CNT_W-1:0]   line_count,
    output logic               err_hcount,
    output logic               err_vcount
);

    localparam int unsigned PIX_W = 3 * COLOR_W;

`ifdef VGA_FRAME_CHECKER_CRC_EN
    localparam logic [31:0] SIG_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;

    // Unrolled MSB-first CRC-32 update over one pixel word
    function automatic logic [31:0] sig_fold(input logic [31:0] acc_in,
                                             input logic [PIX_W-1:0] word);
        logic [31:0] crc;
        crc = acc_in;
        for (int i = 0; i < int'(PIX_W); i++) begin
            if (crc[31] ^ word[PIX_W-1-i]) begin
                crc = {crc[30:0], 1'b0} ^ CRC_POLY;
            end else begin
                crc = {crc[30:0], 1'b0};
            end
        end
        return crc;
    endfunction
`else
    localparam logic [31:0] SIG_INIT = 32'h0000_0000;

    // Additive signature, modulo 2^32
    function automatic logic [31:0] sig_fold(input logic [31:0] acc_in,
                                             input logic [PIX_W-1:0] word);
        return acc_in + 32'(word);
    endfunction
`endif

    // Saturating increment for pixel/line counters
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    typedef enum logic [1:0] {
        S_WAIT_VS = 2'd0,
        S_CAPTURE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t           state;
    logic             vs_q;
    logic             blank_q;
    logic [CNT_W-1:0] pix_cnt;
    logic [CNT_W-1:0] line_cnt;
    logic [31:0]      acc;

    logic [PIX_W-1:0] pix_word_c;
    logic             vs_fall_c;
    logic             line_end_c;
    logic             pix_act_c;
    logic [31:0]      acc_next_c;
    logic [CNT_W-1:0] line_closed_c;
    logic             h_bad_c;
    logic             v_bad_c;
    logic             last_frame_c;

    assign pix_word_c    = {vga_r, vga_g, vga_b};
    assign vs_fall_c     = pix_en & vs_q & ~vga_vs;
    assign line_end_c    = pix_en & blank_q & ~vga_blank;
    assign pix_act_c     = pix_en & vga_blank;
    assign acc_next_c    = pix_act_c ? sig_fold(acc, pix_word_c) : acc;
    // A line ending in the same cycle as VS is counted into the closing frame
    assign line_closed_c = line_end_c ? sat_inc(line_cnt) : line_cnt;
    assign h_bad_c       = line_end_c && (pix_cnt != CNT_W'(H_ACTIVE));
    assign v_bad_c       = (line_closed_c != CNT_W'(V_ACTIVE));
    assign last_frame_c  = ((frame_count + 16'd1) == 16'(NUM_FRAMES));

    // Edge-detect registers, updated only on pixel-enable cycles
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
        end else if (pix_en) begin
            vs_q    <= vga_vs;
            blank_q <= vga_blank;
        end
    end

    // Capture FSM with counters, signature accumulator and registered outputs
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state       <= S_WAIT_VS;
            busy        <= 1'b1;
            done        <= 1'b0;
            frame_done  <= 1'b0;
            frame_sig   <= 32'h0;
            frame_count <= 16'h0;
            line_count  <= '0;
            err_hcount  <= 1'b0;
            err_vcount  <= 1'b0;
            pix_cnt     <= '0;
            line_cnt    <= '0;
            acc         <= 32'h0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_WAIT_VS: begin
                    if (vs_fall_c) begin
                        pix_cnt  <= '0;
                        line_cnt <= '0;
                        acc      <= SIG_INIT;
                        state    <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (pix_act_c) begin
                        pix_cnt <= sat_inc(pix_cnt);
                        acc     <= acc_next_c;
                    end
                    if (line_end_c) begin
                        if (h_bad_c) begin
                            err_hcount <= 1'b1;
                        end
                        line_cnt <= line_closed_c;
                        pix_cnt  <= '0;
                    end
                    if (vs_fall_c) begin
                        frame_sig   <= acc_next_c;
                        line_count  <= line_closed_c;
                        if (v_bad_c) begin
                            err_vcount <= 1'b1;
                        end
                        frame_count <= frame_count + 16'd1;
                        frame_done  <= 1'b1;
                        pix_cnt     <= '0;
                        line_cnt    <= '0;
                        acc         <= SIG_INIT;
                        if (last_frame_c) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (arm) begin
                        frame_count <= 16'h0;
                        err_hcount  <= 1'b0;
                        err_vcount  <= 1'b0;
                        frame_sig   <= 32'h0;
                        line_count  <= '0;
                        state       <= S_WAIT_VS;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                    end
                end
                default: begin
                    state <= S_WAIT_VS;
                    busy  <= 1'b1;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
